// File: rtl/demux_bl_loader.sv
// demux_bl_loader
//   Write-side distributor for an 8-entry register bank. Words on Din are
//   stored into one of eight registered channels, either by a single
//   addressed write (we/ADR in IDLE) or by an 8-word burst (start, then stb)
//   that begins at ADR. The burst pointer increments and wraps modulo 8.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   Din           data word to write
//   ADR           single-write channel / burst base channel
//   we            single write strobe (IDLE only)
//   start         burst start pulse (IDLE only)
//   stb           burst data strobe (LOAD only)
//   D0o..D7o      registered channel contents
//   busy          high while a burst is in progress
//   done          one-cycle pulse after the 8th burst word
//   ptr           current burst write pointer
module demux_bl_loader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       ADR,
  input  logic             we,
  input  logic             start,
  input  logic             stb,
  output logic [WIDTH-1:0] D0o,
  output logic [WIDTH-1:0] D1o,
  output logic [WIDTH-1:0] D2o,
  output logic [WIDTH-1:0] D3o,
  output logic [WIDTH-1:0] D4o,
  output logic [WIDTH-1:0] D5o,
  output logic [WIDTH-1:0] D6o,
  output logic [WIDTH-1:0] D7o,
  output logic             busy,
  output logic             done,
  output logic [2:0]       ptr
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state, state_nx;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] ch [8];
  logic             wr_en;
  logic [2:0]       wr_adr;
  logic             busy_nx;
  logic             done_nx;
  logic             last_word;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (last_word) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / write-control decode
  always_comb begin
    last_word = (state == LOAD) && stb && (cnt == 3'd7);
    wr_en     = ((state == IDLE) && we) || ((state == LOAD) && stb);
    wr_adr    = (state == IDLE) ? ADR : ptr;
    busy_nx   = (state_nx == LOAD);
    done_nx   = last_word;
  end

  // busy and done are flopped so no input reaches an output combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
    end
  end

  // Burst pointer and word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if ((state == IDLE) && start) begin
      ptr <= ADR;
      cnt <= '0;
    end else if ((state == LOAD) && stb) begin
      ptr <= ptr + 3'd1;
      cnt <= cnt + 3'd1;
    end
  end

  // Channel bank: only the addressed entry changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) ch[i] <= '0;
    end else if (wr_en) begin
      ch[wr_adr] <= Din;
    end
  end

  assign D0o = ch[0];
  assign D1o = ch[1];
  assign D2o = ch[2];
  assign D3o = ch[3];
  assign D4o = ch[4];
  assign D5o = ch[5];
  assign D6o = ch[6];
  assign D7o = ch[7];

endmodule

// File: tb/tb_demux_bl_loader.sv
// Testbench for demux_bl_loader: each stimulus cycle updates a behavioural
// model and queues the expected output snapshot; a monitor pops and compares
// every cycle. Directed checks cover asynchronous reset and burst results.
module tb_demux_bl_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Din = '0;
  logic [2:0]  ADR = '0;
  logic        we = 1'b0, start = 1'b0, stb = 1'b0;
  logic [15:0] D0o, D1o, D2o, D3o, D4o, D5o, D6o, D7o;
  logic        busy, done;
  logic [2:0]  ptr;

  always #5 clk = ~clk;

  demux_bl_loader #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .Din(Din), .ADR(ADR), .we(we), .start(start),
    .stb(stb), .D0o(D0o), .D1o(D1o), .D2o(D2o), .D3o(D3o), .D4o(D4o),
    .D5o(D5o), .D6o(D6o), .D7o(D7o), .busy(busy), .done(done), .ptr(ptr)
  );

  typedef struct packed {
    logic [7:0][15:0] ch;
    logic             busy;
    logic             done;
    logic [2:0]       ptr;
  } snap_t;

  snap_t       expq [$];
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;

  // Reference model: channel array plus burst base and words-written count
  logic [15:0] m_ch [8];
  bit          m_loading;
  int          m_base, m_n;
  bit          m_done;

  logic [7:0][15:0] act_ch;
  assign act_ch = {D7o, D6o, D5o, D4o, D3o, D2o, D1o, D0o};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    for (int i = 0; i < 8; i++) s.ch[i] = m_ch[i];
    s.busy = m_loading;
    s.done = m_done;
    s.ptr  = 3'((m_base + m_n) % 8);
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_ch[i] = '0;
    m_loading = 0; m_base = 0; m_n = 0; m_done = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (rst) begin
      model_reset();
    end else if (!m_loading) begin
      if (we) m_ch[ADR] = Din;
      if (start) begin m_loading = 1; m_base = ADR; m_n = 0; end
    end else if (stb) begin
      m_ch[(m_base + m_n) % 8] = Din;
      m_n++;
      if (m_n == 8) begin m_loading = 0; m_done = 1; end
    end
  endtask

  // One clock of stimulus: inputs held across the edge, then model + push
  task automatic cycle(input bit w, input bit s, input bit b, input logic [2:0] a, input logic [15:0] d);
    we = w; start = s; stb = b; ADR = a; Din = d;
    @(posedge clk);
    model_step();
    expq.push_back(model_snap());
    #1;
    we = 0; start = 0; stb = 0;
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next edge
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ch",   128'(act_ch), 128'(0));
    check("async_rst_busy", 128'(busy),   128'(0));
    check("async_rst_done", 128'(done),   128'(0));
    check("async_rst_ptr",  128'(ptr),    128'(0));
    @(posedge clk);
    model_step();
    expq.push_back(model_snap());
    #1;
    rst = 1'b0;
  endtask

  task automatic burst_words(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 1, 3'($urandom_range(0, 7)), 16'($urandom));
  endtask

  // Monitor: compares one queued snapshot per clock
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("channels", 128'(act_ch), 128'(e.ch));
        check("busy",     128'(busy),   128'(e.busy));
        check("done",     128'(done),   128'(e.done));
        check("ptr",      128'(ptr),    128'(e.ptr));
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // write something so the asynchronous reset has state to clear
    cycle(1, 0, 0, 3'd1, 16'h1234);
    async_reset();

    // single write
    cycle(1, 0, 0, 3'd5, 16'hA5A5);
    cycle(0, 0, 0, 3'd0, 16'h0000);
    check("single_D5", 128'(D5o), 128'(16'hA5A5));
    check("single_D4", 128'(D4o), 128'(0));

    // wrapping burst from 6 with a 2-cycle stall after the 3rd word
    cycle(0, 1, 0, 3'd6, 16'h0000);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 3'd0, 16'(16'h1000 + i));
    cycle(0, 0, 0, 3'd0, 16'h0000);
    cycle(0, 0, 0, 3'd0, 16'h0000);
    for (int i = 3; i < 8; i++) cycle(0, 0, 1, 3'd0, 16'(16'h1000 + i));
    check("wrap_done", 128'(done), 128'(1));
    cycle(0, 0, 0, 3'd0, 16'h0000);
    check("wrap_D6",  128'(D6o), 128'(16'h1000));
    check("wrap_D7",  128'(D7o), 128'(16'h1001));
    check("wrap_D0",  128'(D0o), 128'(16'h1002));
    check("wrap_D5",  128'(D5o), 128'(16'h1007));
    check("wrap_ptr", 128'(ptr), 128'(6));
    check("wrap_busy", 128'(busy), 128'(0));

    // we/start ignored in LOAD, stb ignored in IDLE
    cycle(0, 1, 0, 3'd0, 16'h0000);
    cycle(1, 1, 0, 3'd2, 16'hFFFF);
    burst_words(8);
    cycle(0, 0, 1, 3'd4, 16'hBEEF);

    // simultaneous we and start
    cycle(1, 1, 0, 3'd3, 16'h0042);
    check("sim_D3",   128'(D3o),  128'(16'h0042));
    check("sim_busy", 128'(busy), 128'(1));
    check("sim_ptr",  128'(ptr),  128'(3));
    burst_words(8);

    // reset mid-burst, then a fresh burst
    cycle(0, 1, 0, 3'd7, 16'h0000);
    burst_words(4);
    async_reset();
    cycle(0, 1, 0, 3'd2, 16'h0000);
    burst_words(8);

    // back-to-back bursts: start in the done cycle
    cycle(0, 1, 0, 3'd1, 16'h0000);
    burst_words(8);
    cycle(0, 1, 0, 3'd4, 16'h0000);
    burst_words(8);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom));

    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", 128'(expq.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
